branch_predict_unit: RTL and testbench

BRANCH_PREDICT_UNIT -- requirements
Module: branch_predict_unit

---
 rtl/branch_predict_unit_pkg.sv | 21 ++
 rtl/sat_counter2_next.sv | 19 +
 rtl/branch_predict_unit.sv | 105 ++++++++++
 tb/tb_branch_predict_unit.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/branch_predict_unit_pkg.sv
// Shared types and constants for the direct-mapped branch predictor:
// 2-bit counter encodings, default table depth and the table entry record.
package branch_predict_unit_pkg;

    localparam int ENTRIES_DEFAULT = 16;
    // Widest tag occurs at the smallest table (4 entries): PC[31:4].
    localparam int TAG_W_MAX = 28;

    localparam logic [1:0] SNT = 2'd0;
    localparam logic [1:0] WNT = 2'd1;
    localparam logic [1:0] WT  = 2'd2;
    localparam logic [1:0] ST  = 2'd3;

    typedef struct packed {
        logic                 valid;
        logic [TAG_W_MAX-1:0] tag;
        logic [31:0]          target;
        logic [1:0]           ctr;
    } bpu_entry_t;

endpackage

// File: rtl/sat_counter2_next.sv
// Next state of a 2-bit saturating direction counter; purely combinational.
module sat_counter2_next
    import branch_predict_unit_pkg::*;
(
    input  logic [1:0] ctr_i,
    input  logic       taken_i,
    output logic [1:0] ctr_o
);

    always_comb begin
        ctr_o = ctr_i;
        if (taken_i) begin
            if (ctr_i != ST) ctr_o = ctr_i + 2'd1;
        end else begin
            if (ctr_i != SNT) ctr_o = ctr_i - 2'd1;
        end
    end

endmodule

// File: rtl/branch_predict_unit.sv
// Direct-mapped BTB with 2-bit direction counters: zero-latency lookup from fetch,
// update and registered mispredict/redirect/miss-count from EX.
module branch_predict_unit
    import branch_predict_unit_pkg::*;
#(
    parameter int ENTRIES = ENTRIES_DEFAULT
) (
    input  logic        CLOCK,
    input  logic        RESET_N,
    input  logic [31:0] IF_PC,
    output logic        PRED_HIT,
    output logic        PRED_TAKEN,
    output logic [31:0] PRED_TARGET,
    input  logic        EX_VALID,
    input  logic [31:0] EX_PC,
    input  logic        EX_TAKEN,
    input  logic [31:0] EX_TARGET,
    input  logic        EX_PRED_TAKEN,
    input  logic [31:0] EX_PRED_TARGET,
    output logic        MISPREDICT,
    output logic [31:0] REDIRECT_PC,
    output logic [15:0] MISS_COUNT
);

    localparam int IW = $clog2(ENTRIES);

    bpu_entry_t table_q [ENTRIES];

    logic [IW-1:0]        if_idx, ex_idx;
    logic [TAG_W_MAX-1:0] if_tag, ex_tag;
    bpu_entry_t           if_entry, ex_entry, upd_entry_d;
    logic                 ex_hit, upd_we;
    logic [1:0]           ex_ctr_next;

    logic        mispredict_q, mispredict_d;
    logic [31:0] redirect_q, redirect_d;
    logic [15:0] miss_count_q, miss_count_d;

    assign if_idx   = IF_PC[IW+1:2];
    assign if_tag   = TAG_W_MAX'(IF_PC[31:IW+2]);
    assign ex_idx   = EX_PC[IW+1:2];
    assign ex_tag   = TAG_W_MAX'(EX_PC[31:IW+2]);
    assign if_entry = table_q[if_idx];
    assign ex_entry = table_q[ex_idx];

    // Lookup reads the registered table, so a same-cycle update is not visible.
    assign PRED_HIT    = if_entry.valid && (if_entry.tag == if_tag);
    assign PRED_TAKEN  = PRED_HIT && if_entry.ctr[1];
    assign PRED_TARGET = PRED_TAKEN ? if_entry.target : IF_PC + 32'd4;

    assign ex_hit = ex_entry.valid && (ex_entry.tag == ex_tag);

    sat_counter2_next u_ctr_next (
        .ctr_i   (ex_entry.ctr),
        .taken_i (EX_TAKEN),
        .ctr_o   (ex_ctr_next)
    );

    always_comb begin
        upd_entry_d = ex_entry;
        upd_we      = 1'b0;
        if (EX_VALID) begin
            if (ex_hit) begin
                upd_we          = 1'b1;
                upd_entry_d.ctr = ex_ctr_next;
                if (EX_TAKEN) upd_entry_d.target = EX_TARGET;
            end else if (EX_TAKEN) begin
                upd_we      = 1'b1;
                upd_entry_d = '{valid: 1'b1, tag: ex_tag, target: EX_TARGET, ctr: WT};
            end
        end
    end

    always_comb begin
        mispredict_d = EX_VALID && ((EX_TAKEN != EX_PRED_TAKEN) ||
                                    (EX_TAKEN && (EX_TARGET != EX_PRED_TARGET)));
        redirect_d   = redirect_q;
        miss_count_d = miss_count_q;
        if (mispredict_d) begin
            redirect_d = EX_TAKEN ? EX_TARGET : EX_PC + 32'd4;
            if (miss_count_q != 16'hFFFF) miss_count_d = miss_count_q + 16'd1;
        end
    end

    always_ff @(posedge CLOCK) begin
        if (!RESET_N) begin
            for (int i = 0; i < ENTRIES; i++) begin
                table_q[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: WNT};
            end
            mispredict_q <= 1'b0;
            redirect_q   <= '0;
            miss_count_q <= '0;
        end else begin
            if (upd_we) table_q[ex_idx] <= upd_entry_d;
            mispredict_q <= mispredict_d;
            redirect_q   <= redirect_d;
            miss_count_q <= miss_count_d;
        end
    end

    assign MISPREDICT  = mispredict_q;
    assign REDIRECT_PC = redirect_q;
    assign MISS_COUNT  = miss_count_q;

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed bench for branch_predict_unit (ENTRIES=16) with hand-computed expectations.
module tb_branch_predict_unit;

    logic        CLOCK = 1'b0;
    logic        RESET_N;
    logic [31:0] IF_PC;
    logic        PRED_HIT, PRED_TAKEN;
    logic [31:0] PRED_TARGET;
    logic        EX_VALID, EX_TAKEN, EX_PRED_TAKEN;
    logic [31:0] EX_PC, EX_TARGET, EX_PRED_TARGET;
    logic        MISPREDICT;
    logic [31:0] REDIRECT_PC;
    logic [15:0] MISS_COUNT;

    int checks = 0;
    int failures = 0;

    branch_predict_unit #(.ENTRIES(16)) dut (
        .CLOCK          (CLOCK),
        .RESET_N        (RESET_N),
        .IF_PC          (IF_PC),
        .PRED_HIT       (PRED_HIT),
        .PRED_TAKEN     (PRED_TAKEN),
        .PRED_TARGET    (PRED_TARGET),
        .EX_VALID       (EX_VALID),
        .EX_PC          (EX_PC),
        .EX_TAKEN       (EX_TAKEN),
        .EX_TARGET      (EX_TARGET),
        .EX_PRED_TAKEN  (EX_PRED_TAKEN),
        .EX_PRED_TARGET (EX_PRED_TARGET),
        .MISPREDICT     (MISPREDICT),
        .REDIRECT_PC    (REDIRECT_PC),
        .MISS_COUNT     (MISS_COUNT)
    );

    always #5 CLOCK = ~CLOCK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLOCK);
        #1;
    endtask

    // Present one resolved branch for exactly one edge, then drop the strobe.
    task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                       input logic ptk, input logic [31:0] ptgt);
        EX_VALID = 1'b1; EX_PC = pc; EX_TAKEN = tk; EX_TARGET = tgt;
        EX_PRED_TAKEN = ptk; EX_PRED_TARGET = ptgt;
        tick();
        EX_VALID = 1'b0;
        #1;
    endtask

    task automatic look(input string tag, input logic [31:0] pc, input logic hit,
                        input logic tk, input logic [31:0] tgt);
        IF_PC = pc;
        #1;
        chk({tag, "_hit"}, 32'(PRED_HIT), 32'(hit));
        chk({tag, "_taken"}, 32'(PRED_TAKEN), 32'(tk));
        chk({tag, "_target"}, PRED_TARGET, tgt);
    endtask

    initial begin
        RESET_N = 1'b0; IF_PC = '0; EX_VALID = 1'b0; EX_PC = '0; EX_TAKEN = 1'b0;
        EX_TARGET = '0; EX_PRED_TAKEN = 1'b0; EX_PRED_TARGET = '0;
        tick(); tick();
        RESET_N = 1'b1;

        look("reset", 32'h100, 1'b0, 1'b0, 32'h104);
        chk("reset_misp", 32'(MISPREDICT), 32'd0);
        chk("reset_redir", REDIRECT_PC, 32'd0);
        chk("reset_cnt", 32'(MISS_COUNT), 32'd0);

        // Allocate 0x100 via a taken mispredict; counter becomes 2.
        upd(32'h100, 1'b1, 32'h200, 1'b0, 32'h0);
        chk("alloc_misp", 32'(MISPREDICT), 32'd1);
        chk("alloc_redir", REDIRECT_PC, 32'h200);
        chk("alloc_cnt", 32'(MISS_COUNT), 32'd1);
        look("alloc", 32'h100, 1'b1, 1'b1, 32'h200);
        tick();
        chk("misp_one_cycle", 32'(MISPREDICT), 32'd0);
        chk("redir_hold", REDIRECT_PC, 32'h200);

        // Four correctly predicted not-taken updates: 2,1,0,0.
        upd(32'h100, 1'b0, 32'h0, 1'b0, 32'h0);
        look("dec1", 32'h100, 1'b1, 1'b0, 32'h104);
        for (int i = 0; i < 3; i++) upd(32'h100, 1'b0, 32'h0, 1'b0, 32'h0);
        look("dec4", 32'h100, 1'b1, 1'b0, 32'h104);
        chk("dec_no_misp", 32'(MISS_COUNT), 32'd1);
        // From 0: one taken -> 1 (still not taken), second -> 2 (taken).
        upd(32'h100, 1'b1, 32'h200, 1'b1, 32'h200);
        look("inc1", 32'h100, 1'b1, 1'b0, 32'h104);
        upd(32'h100, 1'b1, 32'h200, 1'b1, 32'h200);
        look("inc2", 32'h100, 1'b1, 1'b1, 32'h200);
        // Up to 3 and beyond, then one not-taken leaves it at 2 (still taken).
        upd(32'h100, 1'b1, 32'h200, 1'b1, 32'h200);
        upd(32'h100, 1'b1, 32'h200, 1'b1, 32'h200);
        upd(32'h100, 1'b0, 32'h0, 1'b1, 32'h200);
        chk("nt_misp", 32'(MISPREDICT), 32'd1);
        chk("nt_redir", REDIRECT_PC, 32'h104);
        chk("nt_cnt", 32'(MISS_COUNT), 32'd2);
        look("sat3", 32'h100, 1'b1, 1'b1, 32'h200);

        // Correct direction but wrong target is a mispredict and retargets the entry.
        upd(32'h100, 1'b1, 32'h300, 1'b1, 32'h200);
        chk("tgt_misp", 32'(MISPREDICT), 32'd1);
        chk("tgt_redir", REDIRECT_PC, 32'h300);
        chk("tgt_cnt", 32'(MISS_COUNT), 32'd3);
        look("retarget", 32'h100, 1'b1, 1'b1, 32'h300);

        // 0x140 shares index 0 with 0x100 but has a different tag.
        upd(32'h140, 1'b1, 32'h400, 1'b0, 32'h0);
        chk("alias_cnt", 32'(MISS_COUNT), 32'd4);
        look("alias_old", 32'h100, 1'b0, 1'b0, 32'h104);
        look("alias_new", 32'h140, 1'b1, 1'b1, 32'h400);

        // Not-taken miss leaves the table alone.
        upd(32'h100, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("ntmiss_misp", 32'(MISPREDICT), 32'd0);
        look("ntmiss", 32'h140, 1'b1, 1'b1, 32'h400);
        look("ntmiss_old", 32'h100, 1'b0, 1'b0, 32'h104);

        // Same-cycle lookup/update: old contents now, new contents after the edge.
        IF_PC = 32'h140;
        EX_VALID = 1'b1; EX_PC = 32'h140; EX_TAKEN = 1'b0; EX_TARGET = '0;
        EX_PRED_TAKEN = 1'b0; EX_PRED_TARGET = '0;
        #1;
        chk("bypass_old", 32'(PRED_TAKEN), 32'd1);
        tick();
        EX_VALID = 1'b0;
        look("bypass_new", 32'h140, 1'b1, 1'b0, 32'h144);

        // Reset wins over a concurrent update.
        RESET_N = 1'b0;
        EX_VALID = 1'b1; EX_PC = 32'h180; EX_TAKEN = 1'b1; EX_TARGET = 32'h500;
        EX_PRED_TAKEN = 1'b0; EX_PRED_TARGET = '0;
        tick();
        RESET_N = 1'b1; EX_VALID = 1'b0;
        look("rst_upd", 32'h180, 1'b0, 1'b0, 32'h184);
        look("rst_clr", 32'h140, 1'b0, 1'b0, 32'h144);
        chk("rst_misp", 32'(MISPREDICT), 32'd0);
        chk("rst_redir", REDIRECT_PC, 32'd0);
        chk("rst_cnt", 32'(MISS_COUNT), 32'd0);

        // 32-bit wrap of PC+4 on both paths.
        look("wrap", 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0);
        upd(32'hFFFF_FFFC, 1'b0, 32'h0, 1'b1, 32'h0);
        chk("wrap_redir", REDIRECT_PC, 32'h0);
        chk("wrap_cnt", 32'(MISS_COUNT), 32'd1);

        // 65540 back-to-back mispredicts: count saturates, flag stays high every cycle.
        EX_VALID = 1'b1; EX_PC = 32'h20; EX_TAKEN = 1'b0; EX_PRED_TAKEN = 1'b1;
        for (int i = 0; i < 65540; i++) tick();
        chk("b2b_misp", 32'(MISPREDICT), 32'd1);
        chk("sat_cnt", 32'(MISS_COUNT), 32'hFFFF);
        EX_VALID = 1'b0;
        tick();
        chk("sat_hold", 32'(MISS_COUNT), 32'hFFFF);
        chk("sat_misp_low", 32'(MISPREDICT), 32'd0);
        chk("sat_redir", REDIRECT_PC, 32'h24);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
